// File: rtl/skinny_sbox_layer_ctrl.sv
// skinny_sbox_layer_ctrl
//   Sequencer for one masked SKINNY-64 S-box layer. Streams the NPAIRS bytes of
//   a 3-share state through one shared masked S-box pair datapath, one byte per
//   pass. Passes are issued only when fresh randomness is offered. In-flight
//   passes are tracked through the datapath's fixed LAT-cycle pipeline, and each
//   retired byte is written back into the 3-share output state.
//
//   Build option: define SBOX_CTRL_ZEROIZE_EN to clear the captured input shares
//   in the DONE cycle. It also makes bubble cycles repeat the previously issued
//   byte on sb_in*, so the datapath sees no zero-value toggles.
//
// Ports
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   start_i                     begin a layer (sampled in IDLE only)
//   st_in{1,2,3}_i              input state shares, captured at start
//   busy_o, done_o              layer in progress / one-cycle completion pulse
//   st_out{1,2,3}_o             registered output state shares
//   rnd_valid_i/rnd_data_i      fresh randomness offer (one pass worth)
//   rnd_ready_o                 randomness consumed this cycle (combinational)
//   sb_in{1,2,3}_o, sb_r_o      datapath inputs (zero outside issue cycles)
//   sb_out{1,2,3}_i             datapath outputs, LAT cycles after sb_in*
module skinny_sbox_layer_ctrl #(
  parameter int LAT    = 4,
  parameter int NPAIRS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [8*NPAIRS-1:0]   st_in1_i,
  input  logic [8*NPAIRS-1:0]   st_in2_i,
  input  logic [8*NPAIRS-1:0]   st_in3_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [8*NPAIRS-1:0]   st_out1_o,
  output logic [8*NPAIRS-1:0]   st_out2_o,
  output logic [8*NPAIRS-1:0]   st_out3_o,
  input  logic                  rnd_valid_i,
  input  logic [143:0]          rnd_data_i,
  output logic                  rnd_ready_o,
  output logic [7:0]            sb_in1_o,
  output logic [7:0]            sb_in2_o,
  output logic [7:0]            sb_in3_o,
  output logic [143:0]          sb_r_o,
  input  logic [7:0]            sb_out1_i,
  input  logic [7:0]            sb_out2_i,
  input  logic [7:0]            sb_out3_i
);

  localparam int IW = $clog2(NPAIRS);
  localparam int CW = $clog2(NPAIRS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                   state_q;
  logic [CW-1:0]            icnt_q, rcnt_q;
  logic [NPAIRS-1:0][7:0]   sh1_q, sh2_q, sh3_q;
  logic [NPAIRS-1:0][7:0]   out1_q, out2_q, out3_q;
  logic [LAT-1:0]           vld_q;
  logic [LAT-1:0][IW-1:0]   tag_q;
  logic                     busy_q, done_q;

  logic                     issue, retire, last_issue, last_retire;
  logic [IW-1:0]            iidx, ridx;

  assign iidx        = icnt_q[IW-1:0];
  assign ridx        = tag_q[LAT-1];
  assign issue       = (state_q == ISSUE) && rnd_valid_i;
  assign retire      = vld_q[LAT-1];
  assign last_issue  = issue && (icnt_q == CW'(NPAIRS - 1));
  // The final retirement moves straight to DONE so that done appears in the
  // cycle right after the last write-back.
  assign last_retire = retire && (rcnt_q == CW'(NPAIRS - 1));

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign st_out1_o   = out1_q;
  assign st_out2_o   = out2_q;
  assign st_out3_o   = out3_q;

`ifdef SBOX_CTRL_ZEROIZE_EN
  logic [IW-1:0] pidx;
  assign pidx = iidx - IW'(1);
`endif

  always_comb begin
    rnd_ready_o = issue;
    sb_r_o      = issue ? rnd_data_i : '0;
    sb_in1_o    = '0;
    sb_in2_o    = '0;
    sb_in3_o    = '0;
    if (issue) begin
      sb_in1_o = sh1_q[iidx];
      sb_in2_o = sh2_q[iidx];
      sb_in3_o = sh3_q[iidx];
    end
`ifdef SBOX_CTRL_ZEROIZE_EN
    // Bubble: hold the last issued byte; nothing issued yet means zeros.
    else if (state_q == ISSUE && icnt_q != '0) begin
      sb_in1_o = sh1_q[pidx];
      sb_in2_o = sh2_q[pidx];
      sb_in3_o = sh3_q[pidx];
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
    end else begin
      // Tracking shadow of the datapath pipeline; shifts every cycle because
      // the datapath itself has no enable.
      vld_q[0] <= issue;
      tag_q[0] <= iidx;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end

      if (issue) icnt_q <= icnt_q + CW'(1);

      if (retire) begin
        out1_q[ridx] <= sb_out1_i;
        out2_q[ridx] <= sb_out2_i;
        out3_q[ridx] <= sb_out3_i;
        rcnt_q       <= rcnt_q + CW'(1);
      end

      case (state_q)
        IDLE: if (start_i) begin
          sh1_q   <= st_in1_i;
          sh2_q   <= st_in2_i;
          sh3_q   <= st_in3_i;
          icnt_q  <= '0;
          rcnt_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: if (last_issue) state_q <= DRAIN;
        DRAIN: if (last_retire) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef SBOX_CTRL_ZEROIZE_EN
          sh1_q   <= '0;
          sh2_q   <= '0;
          sh3_q   <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
module tb_skinny_sbox_layer_ctrl;
  localparam int LAT = 4;
  localparam int NP  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   st_in1 = '0, st_in2 = '0, st_in3 = '0;
  logic          busy, done, rnd_ready;
  logic [63:0]   st_out1, st_out2, st_out3;
  logic          rnd_valid = 1'b0;
  logic [143:0]  rnd_data = '0;
  logic [7:0]    sb_in1, sb_in2, sb_in3;
  logic [143:0]  sb_r;
  logic [7:0]    sb_out1, sb_out2, sb_out3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skinny_sbox_layer_ctrl #(.LAT(LAT), .NPAIRS(NP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .st_in1_i(st_in1), .st_in2_i(st_in2), .st_in3_i(st_in3),
    .busy_o(busy), .done_o(done),
    .st_out1_o(st_out1), .st_out2_o(st_out2), .st_out3_o(st_out3),
    .rnd_valid_i(rnd_valid), .rnd_data_i(rnd_data), .rnd_ready_o(rnd_ready),
    .sb_in1_o(sb_in1), .sb_in2_o(sb_in2), .sb_in3_o(sb_in3), .sb_r_o(sb_r),
    .sb_out1_i(sb_out1), .sb_out2_i(sb_out2), .sb_out3_i(sb_out3)
  );

  // SKINNY-64 4-bit S-box
  function automatic logic [3:0] sb4(input logic [3:0] x);
    case (x)
      4'h0: sb4 = 4'hc; 4'h1: sb4 = 4'h6; 4'h2: sb4 = 4'h9; 4'h3: sb4 = 4'h0;
      4'h4: sb4 = 4'h1; 4'h5: sb4 = 4'ha; 4'h6: sb4 = 4'h2; 4'h7: sb4 = 4'hb;
      4'h8: sb4 = 4'h3; 4'h9: sb4 = 4'h8; 4'ha: sb4 = 4'h5; 4'hb: sb4 = 4'hd;
      4'hc: sb4 = 4'h4; 4'hd: sb4 = 4'he; 4'he: sb4 = 4'h7; default: sb4 = 4'hf;
    endcase
  endfunction

  function automatic logic [63:0] layer(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb4(v[4*i +: 4]);
    return r;
  endfunction

  // Behavioural masked datapath: LAT-deep, no enable, no reset; output shares
  // XOR to the S-box of the unmasked input, remasked from sb_r.
  logic [7:0] dp1 [LAT];
  logic [7:0] dp2 [LAT];
  logic [7:0] dp3 [LAT];
  always @(posedge clk) begin
    logic [7:0] x, y;
    x = sb_in1 ^ sb_in2 ^ sb_in3;
    y = {sb4(x[7:4]), sb4(x[3:0])};
    for (int i = LAT - 1; i > 0; i--) begin
      dp1[i] <= dp1[i-1]; dp2[i] <= dp2[i-1]; dp3[i] <= dp3[i-1];
    end
    dp1[0] <= y ^ sb_r[7:0] ^ sb_r[15:8];
    dp2[0] <= sb_r[7:0];
    dp3[0] <= sb_r[15:8];
  end
  assign sb_out1 = dp1[LAT-1];
  assign sb_out2 = dp2[LAT-1];
  assign sb_out3 = dp3[LAT-1];

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready: got %b want 0", rnd_ready); end
    checks++; if ({sb_in1, sb_in2, sb_in3} !== 24'h0 || sb_r !== '0) begin
      errors++; $display("FAIL reset_sb: got sb_in=%h want 0", {sb_in1, sb_in2, sb_in3}); end
    checks++; if ({st_out1, st_out2, st_out3} !== '0) begin
      errors++; $display("FAIL reset_st_out: got %h want 0", st_out1 ^ st_out2 ^ st_out3); end
    @(negedge clk); rst_n = 1'b1; rnd_valid = 1'b0;
  endtask

  // mode: 0 = rnd_valid always 1, 1 = toggling 1,0,..., 2 = low for 20 cycles,
  // 3 = random. sp1/sp2: cycles with an extra start pulse. want_done: spec
  // cycle for done (0 = use the issue model). tail: cycles watched after done.
  task automatic run_layer(input string nm, input logic [63:0] v, input bit split,
                           input int mode, input int sp1, input int sp2,
                           input int want_done, input int tail);
    logic [63:0]  s1, s2, s3;
    logic [159:0] r;
    logic         exp_rdy;
    int issued = 0, exp_done = 0, done_cyc = 0, dcnt = 0, rdy_cnt = 0;
    int bad_rdy = 0, bad_sb = 0, bad_busy = 0;
    s2 = split ? rnd64() : 64'h0;
    s3 = split ? rnd64() : 64'h0;
    s1 = v ^ s2 ^ s3;
    @(negedge clk);
    st_in1 = s1; st_in2 = s2; st_in3 = s3; start = 1'b1; rnd_valid = 1'b0;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      start = (cyc == sp1) || (cyc == sp2);
      // Garbage on the inputs: captured shares must not follow them.
      st_in1 = rnd64(); st_in2 = rnd64(); st_in3 = rnd64();
      case (mode)
        0: rnd_valid = 1'b1;
        1: rnd_valid = (cyc % 2) == 1;
        2: rnd_valid = cyc > 20;
        default: rnd_valid = 1'($urandom_range(0, 1));
      endcase
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rnd_data = r[143:0];
      #1;
      exp_rdy = rnd_valid && (issued < NP);
      if (rnd_ready !== exp_rdy) bad_rdy++;
      if (rnd_ready === 1'b1) rdy_cnt++;
      if (exp_rdy) begin
        if (sb_r !== rnd_data ||
            {sb_in1, sb_in2, sb_in3} !== {s1[8*issued +: 8], s2[8*issued +: 8], s3[8*issued +: 8]})
          bad_sb++;
        issued++;
        if (issued == NP) exp_done = cyc + LAT + 1;
      end else begin
        if (sb_r !== '0) bad_sb++;
        if (issued == 0 && {sb_in1, sb_in2, sb_in3} !== 24'h0) bad_sb++;
      end
      if (busy !== ((exp_done == 0) || (cyc <= exp_done))) bad_busy++;
      if (done === 1'b1) begin
        dcnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (exp_done != 0 && cyc >= exp_done + tail) break;
    end
    start = 1'b0;
    if (want_done == 0) want_done = exp_done;
    checks++; if (done_cyc != want_done) begin errors++;
      $display("FAIL %s_done_cycle: got %0d want %0d", nm, done_cyc, want_done); end
    checks++; if (dcnt != 1) begin errors++;
      $display("FAIL %s_done_pulses: got %0d want 1", nm, dcnt); end
    checks++; if (rdy_cnt != NP) begin errors++;
      $display("FAIL %s_rnd_ready_pulses: got %0d want %0d", nm, rdy_cnt, NP); end
    checks++; if (bad_rdy != 0) begin errors++;
      $display("FAIL %s_rnd_ready_cycles: got %0d bad cycles want 0", nm, bad_rdy); end
    checks++; if (bad_sb != 0) begin errors++;
      $display("FAIL %s_sb_drive: got %0d bad cycles want 0", nm, bad_sb); end
    checks++; if (bad_busy != 0) begin errors++;
      $display("FAIL %s_busy: got %0d bad cycles want 0", nm, bad_busy); end
    checks++; if ((st_out1 ^ st_out2 ^ st_out3) !== layer(v)) begin errors++;
      $display("FAIL %s_result: got %h want %h", nm, st_out1 ^ st_out2 ^ st_out3, layer(v)); end
  endtask

  task automatic test_basic();
    run_layer("basic", 64'h0123456789ABCDEF, 1'b0, 0, 0, 0, 13, 3);
  endtask

  task automatic test_toggle();
    run_layer("toggle", 64'h0123456789ABCDEF, 1'b1, 1, 0, 0, 20, 3);
  endtask

  task automatic test_starve();
    run_layer("starve", rnd64(), 1'b1, 2, 0, 0, 33, 3);
  endtask

  task automatic test_start_ignored();
    run_layer("start_ign", rnd64(), 1'b1, 0, 4, 10, 13, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) run_layer("random", rnd64(), 1'b1, 3, 0, 0, 0, 2);
  endtask

  task automatic test_back_to_back();
    run_layer("b2b_a", rnd64(), 1'b1, 0, 0, 0, 13, 0);
    run_layer("b2b_b", rnd64(), 1'b1, 3, 0, 0, 0, 2);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    st_in1 = rnd64(); st_in2 = rnd64(); st_in3 = 64'h0; start = 1'b1; rnd_valid = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 6) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL rstmid_busy_done: got %b%b want 00", busy, done); end
    checks++; if (rnd_ready !== 1'b0 || sb_r !== '0 || {sb_in1, sb_in2, sb_in3} !== 24'h0) begin errors++;
      $display("FAIL rstmid_datapath_drive: got rdy=%b sb_in=%h want 0", rnd_ready, {sb_in1, sb_in2, sb_in3}); end
    checks++; if ({st_out1, st_out2, st_out3} !== '0) begin errors++;
      $display("FAIL rstmid_st_out: got %h want 0", st_out1 ^ st_out2 ^ st_out3); end
    // Late datapath results of the aborted passes arrive over these cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if ({st_out1, st_out2, st_out3} !== '0 || busy !== 1'b0 || done !== 1'b0 || rnd_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL rstmid_late_results: got %0d bad cycles want 0", bad); end
    rnd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin dp1[i] = '0; dp2[i] = '0; dp3[i] = '0; end
    test_reset();
    test_basic();
    test_toggle();
    test_starve();
    test_start_ignored();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
